// File: rtl/xmm_pkg.sv
// Shared definitions for the XMM register file family: default geometry,
// clear-sequencer state encoding and q15.48 format constants.
package xmm_pkg;

    localparam int XMM_DATA_W  = 64;
    localparam int XMM_DEPTH   = 32;

    localparam int Q_FRAC_BITS = 48;
    localparam int Q_INT_BITS  = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } xmm_state_e;

endpackage

// File: rtl/xmm_clear_seq.sv
// Clear sequencer: sweeps one entry per cycle for DEPTH cycles after clear_req.
// Writes arriving while busy are refused and reported by a one-cycle wr_dropped pulse.
module xmm_clear_seq
    import xmm_pkg::*;
#(
    parameter int DEPTH  = XMM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_req,
    input  logic              wr_en,
    output logic              clear_busy,
    output logic              wr_dropped,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    xmm_state_e        state;
    logic [ADDR_W-1:0] clear_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clear_ptr  <= '0;
            clear_busy <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= wr_en & clear_busy;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_ptr  <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clear_req is deliberately not looked at here: a sweep is never restarted
                    clear_ptr <= clear_ptr + ADDR_W'(1);
                    if (clear_ptr == LAST) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = clear_busy;
    assign clr_addr = clear_ptr;

endmodule

// File: rtl/xmm_regfile_param.sv
// Parametrised XMM register file: two combinational read ports with write bypass,
// one posedge write port, optional hard-wired zero register and a hardware clear sweep.
module xmm_regfile_param
    import xmm_pkg::*;
#(
    parameter int DATA_W   = XMM_DATA_W,
    parameter int DEPTH    = XMM_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              wr_dropped
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] entry [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;
    logic              wr_commit;

    xmm_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .clear_busy (clear_busy),
        .wr_dropped (wr_dropped),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    assign wr_ready  = ~clear_busy;
    assign wr_fire   = wr_en & wr_ready;
    // A write to the zero register is accepted on the handshake but never stored
    assign wr_commit = wr_fire & ~(HAS_ZERO && (wr_addr == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (clr_we) begin
            entry[clr_addr] <= '0;
        end else if (wr_commit) begin
            entry[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (clear_busy || (HAS_ZERO && (rd_addr1 == '0))) ? '0 :
                      (wr_fire && (wr_addr == rd_addr1))             ? wr_data :
                                                                        entry[rd_addr1];

    assign rd_data2 = (clear_busy || (HAS_ZERO && (rd_addr2 == '0))) ? '0 :
                      (wr_fire && (wr_addr == rd_addr2))             ? wr_data :
                                                                        entry[rd_addr2];

endmodule

// File: tb/tb_xmm_regfile_param.sv
// Bench for xmm_regfile_param: default 64x32 instance and a 32x8 no-zero-register
// instance share one directed stimulus stream and are checked against a behavioural model.
module tb_xmm_regfile_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        clear_req = 1'b0;

    logic [63:0] rd1_a, rd2_a;
    logic [31:0] rd1_b, rd2_b;
    logic        rdy_a, busy_a, drp_a;
    logic        rdy_b, busy_b, drp_b;

    logic [63:0] rd1_act [2];
    logic [63:0] rd2_act [2];
    logic        busy_act [2];
    logic        rdy_act [2];
    logic        drp_act [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: stored contents, cycles of sweep remaining, pending drop pulse
    logic [63:0] m_mem [2][32];
    int          m_left [2];
    bit          m_drop [2];

    always #5 clk = ~clk;

    xmm_regfile_param u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd1_a),
        .rd_data2   (rd2_a),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (rdy_a),
        .clear_req  (clear_req),
        .clear_busy (busy_a),
        .wr_dropped (drp_a)
    );

    xmm_regfile_param #(
        .DATA_W   (32),
        .DEPTH    (8),
        .ZERO_REG (0)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr1   (rd_addr1[2:0]),
        .rd_addr2   (rd_addr2[2:0]),
        .rd_data1   (rd1_b),
        .rd_data2   (rd2_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr[2:0]),
        .wr_data    (wr_data[31:0]),
        .wr_ready   (rdy_b),
        .clear_req  (clear_req),
        .clear_busy (busy_b),
        .wr_dropped (drp_b)
    );

    assign rd1_act[0]  = rd1_a;
    assign rd1_act[1]  = {32'd0, rd1_b};
    assign rd2_act[0]  = rd2_a;
    assign rd2_act[1]  = {32'd0, rd2_b};
    assign busy_act[0] = busy_a;
    assign busy_act[1] = busy_b;
    assign rdy_act[0]  = rdy_a;
    assign rdy_act[1]  = rdy_b;
    assign drp_act[0]  = drp_a;
    assign drp_act[1]  = drp_b;

    function automatic int dep(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic bit has_zero(input int i);
        return (i == 0);
    endfunction

    function automatic logic [63:0] dmask(input int i);
        return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) m_mem[i][j] = '0;
            m_left[i] = 0;
            m_drop[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int wa;
        if (!reset_n) return;
        for (int i = 0; i < 2; i++) begin
            wa = int'(wr_addr) & (dep(i) - 1);
            m_drop[i] = wr_en && (m_left[i] > 0);
            if (m_left[i] > 0) begin
                m_left[i]--;
            end else begin
                if (wr_en && !(has_zero(i) && wa == 0)) m_mem[i][wa] = wr_data & dmask(i);
                // Reads are forced to zero for the whole sweep, so the model empties at once
                if (clear_req) begin
                    for (int j = 0; j < 32; j++) m_mem[i][j] = '0;
                    m_left[i] = dep(i);
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_rd(input int i, input logic [4:0] a);
        int aa;
        int wa;
        aa = int'(a) & (dep(i) - 1);
        wa = int'(wr_addr) & (dep(i) - 1);
        if (m_left[i] > 0) return '0;
        if (has_zero(i) && aa == 0) return '0;
        if (wr_en && wa == aa) return wr_data & dmask(i);
        return m_mem[i][aa];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), {63'd0, busy_act[i]}, {63'd0, (m_left[i] > 0)});
                chk($sformatf("wr_ready[%0d]", i), {63'd0, rdy_act[i]}, {63'd0, (m_left[i] == 0)});
                chk($sformatf("wr_dropped[%0d]", i), {63'd0, drp_act[i]}, {63'd0, m_drop[i]});
                chk($sformatf("rd_data1[%0d]", i), rd1_act[i], exp_rd(i, rd_addr1));
                chk($sformatf("rd_data2[%0d]", i), rd2_act[i], exp_rd(i, rd_addr2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && busy_a; n++) tick();
        chk("wait_idle_timeout", {63'd0, busy_a}, 64'd0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;

        // Reset, then every address reads zero
        #1;
        reset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            tick();
        end
        rd_addr1 = 5'd17;
        #1;
        chk("reset_r17", rd1_a, 64'd0);
        chk("reset_ready", {63'd0, rdy_a}, 64'd1);

        // Basic write then read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0001_0000_0000_0000;
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        #1;
        chk("r5_port1", rd1_a, 64'h0001_0000_0000_0000);
        chk("r5_port2", rd2_a, 64'h0001_0000_0000_0000);
        tick();

        // Same-cycle bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD_BEEF_0000_0001; rd_addr1 = 5'd7;
        #1;
        chk("bypass_a", rd1_a, 64'hDEAD_BEEF_0000_0001);
        chk("bypass_b", {32'd0, rd1_b}, 64'h0000_0000_0000_0001);
        tick();

        // Zero register ignores writes without a drop pulse
        wr_addr = 5'd0; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; rd_addr1 = 5'd0;
        #1;
        chk("r0_bypass_blocked", rd1_a, 64'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_after_write", rd1_a, 64'd0);
        chk("r0_no_drop", {63'd0, drp_a}, 64'd0);
        tick();

        // Fill r1..r31 with their index, then a plain sweep
        for (int a = 1; a < 32; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 64'(a);
            tick();
        end
        wr_en = 1'b0; rd_addr1 = 5'd31;
        #1;
        chk("r31_filled", rd1_a, 64'd31);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            rd_addr1 = 5'(c); rd_addr2 = 5'(c + 3);
            #1;
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            tick();
        end
        chk("sweep_len_a", 64'(cnt_a), 64'd32);
        chk("sweep_len_b", 64'(cnt_b), 64'd8);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a);
            tick();
        end

        // Rejected write and ignored second clear_req mid-sweep
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
        tick();
        wr_en = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt_a = 0;
        for (int c = 1; c <= 40; c++) begin
            wr_en = (c == 10); wr_addr = 5'd3; wr_data = 64'h1234;
            clear_req = (c == 20); rd_addr1 = 5'd3; rd_addr2 = 5'(c);
            #1;
            if (busy_a) cnt_a++;
            if (c == 10) chk("wr_ready_low_in_clear", {63'd0, rdy_a}, 64'd0);
            if (c == 11) chk("wr_dropped_pulse", {63'd0, drp_a}, 64'd1);
            if (c == 12) chk("wr_dropped_one_cycle", {63'd0, drp_a}, 64'd0);
            tick();
        end
        wr_en = 1'b0; clear_req = 1'b0;
        chk("sweep_not_extended", 64'(cnt_a), 64'd32);
        wait_idle();
        rd_addr1 = 5'd3;
        #1;
        chk("r3_after_sweep", rd1_a, 64'd0);

        // Write and clear_req together in IDLE
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55; clear_req = 1'b1; rd_addr1 = 5'd9;
        #1;
        chk("simul_bypass", rd1_a, 64'h55);
        tick();
        wr_en = 1'b0; clear_req = 1'b0;
        #1;
        chk("simul_busy", {63'd0, busy_a}, 64'd1);
        wait_idle();
        #1;
        chk("r9_after_sweep", rd1_a, 64'd0);

        // Reset in the middle of a sweep, before r20 has been reached
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h99;
        tick();
        wr_en = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        reset_n = 1'b0;
        model_reset();
        rd_addr1 = 5'd20;
        #1;
        chk("reset_mid_busy", {63'd0, busy_a}, 64'd0);
        chk("reset_mid_r20", rd1_a, 64'd0);
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a); rd_addr2 = 5'(a ^ 5);
            tick();
        end

        // r0 is ordinary storage in the 32x8 instance
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF_FFFF_A5A5_A5A5;
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd0;
        #1;
        chk("b_r0_holds", {32'd0, rd1_b}, 64'h0000_0000_A5A5_A5A5);
        chk("a_r0_zero", rd1_a, 64'd0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
